spi_bus_arb: RTL and testbench

Arbiter and sequencer for the DSO digital core's single shared SPI bus. Two requesters share one SPI master and its five slave selects: the command processor (gain pots, trigger pot, EEPROM commands) and the calibration/housekeeping engine. The block grants the bus round-robin, drives the target slave select, launches the SPI master, and returns read data and a completion strobe to the winner. It sits between the requesters and the existing 16-bit SPI master.

---
 rtl/spi_bus_arb_if.sv | 24 ++
 rtl/spi_bus_arb.sv | 188 ++++++++++++++++++
 tb/tb_spi_bus_arb.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_bus_arb_if.sv
// Requester-side handshake bundle for the shared SPI bus arbiter.
// The master modport is the requester pair; the slave modport is the arbiter.
interface spi_bus_arb_if;
  logic [1:0]  req;
  logic [1:0]  lock;
  logic [2:0]  sel0;
  logic [2:0]  sel1;
  logic [15:0] cmd0;
  logic [15:0] cmd1;
  logic [1:0]  gnt;
  logic [1:0]  done;
  logic        err;
  logic [15:0] rd_data;

  modport master (
    output req, lock, sel0, sel1, cmd0, cmd1,
    input  gnt, done, err, rd_data
  );

  modport slave (
    input  req, lock, sel0, sel1, cmd0, cmd1,
    output gnt, done, err, rd_data
  );
endinterface

// File: rtl/spi_bus_arb.sv
// Round-robin arbiter and sequencer for the single shared SPI master and its
// five slave selects; returns read data and a completion strobe to the grantee.
module spi_bus_arb #(
  parameter int GAP_CYC = 4,
  parameter int TMO_CYC = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  spi_bus_arb_if.slave bus,
  output logic         spi_wrt,
  output logic [15:0]  spi_cmd,
  input  logic         spi_done,
  input  logic [15:0]  spi_rd_data,
  output logic         trig_ss_n,
  output logic         ch1_ss_n,
  output logic         ch2_ss_n,
  output logic         ch3_ss_n,
  output logic         EEP_ss_n
);

  localparam int MAXC = (TMO_CYC > GAP_CYC) ? TMO_CYC : GAP_CYC;
  localparam int CW   = $clog2(MAXC) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    GAP   = 2'd3
  } state_t;

  // Active-low select vector ordered {EEP, ch3, ch2, ch1, trig}.
  function automatic logic [4:0] ss_decode(input logic [2:0] sel);
    logic [4:0] ss;
    case (sel)
      3'd0:    ss = 5'b11110;
      3'd1:    ss = 5'b11101;
      3'd2:    ss = 5'b11011;
      3'd3:    ss = 5'b10111;
      3'd4:    ss = 5'b01111;
      default: ss = 5'b11111;
    endcase
    return ss;
  endfunction

  function automatic logic sel_valid(input logic [2:0] sel);
    return (sel <= 3'd4);
  endfunction

  state_t      state_r, state_nxt;
  logic [1:0]  gnt_r, gnt_nxt;
  logic [1:0]  done_r, done_nxt;
  logic        err_r, err_nxt;
  logic [15:0] rd_data_r, rd_nxt;
  logic        spi_wrt_r, wrt_nxt;
  logic [15:0] spi_cmd_r, cmd_nxt;
  logic [4:0]  ss_n_r, ss_nxt;
  logic        sel_ok_r, ok_nxt;
  logic [CW-1:0] cnt_r, cnt_nxt;
  logic        last_r, last_nxt;
  logic        grant_s;
  logic        win_s;
  logic        gi_s;
  logic [2:0]  sel_s;
  logic [15:0] cmd_s;

  // When both request, the one not served last wins; from GAP the grantee is kept.
  assign win_s = (bus.req == 2'b11) ? ~last_r : bus.req[1];
  assign gi_s  = (state_r == IDLE) ? win_s : gnt_r[1];
  assign sel_s = gi_s ? bus.sel1 : bus.sel0;
  assign cmd_s = gi_s ? bus.cmd1 : bus.cmd0;

  // Next-state and next-output logic for the grant/transfer sequencer.
  always_comb begin
    state_nxt = state_r;
    gnt_nxt   = gnt_r;
    done_nxt  = 2'b00;
    err_nxt   = 1'b0;
    rd_nxt    = rd_data_r;
    wrt_nxt   = 1'b0;
    cmd_nxt   = spi_cmd_r;
    ss_nxt    = ss_n_r;
    ok_nxt    = sel_ok_r;
    cnt_nxt   = cnt_r;
    last_nxt  = last_r;
    grant_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (|bus.req) begin
          grant_s = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      SETUP: begin
        cnt_nxt = '0;
        if (sel_ok_r) begin
          state_nxt = XFER;
        end else begin
          state_nxt = GAP;
          done_nxt  = gnt_r;
          err_nxt   = 1'b1;
        end
      end
      XFER: begin
        if (spi_done) begin
          rd_nxt    = spi_rd_data;
          ss_nxt    = 5'b11111;
          done_nxt  = gnt_r;
          cnt_nxt   = '0;
          state_nxt = GAP;
        end else if (cnt_r == CW'(TMO_CYC - 1)) begin
          ss_nxt    = 5'b11111;
          done_nxt  = gnt_r;
          err_nxt   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = GAP;
        end else begin
          cnt_nxt = cnt_r + CW'(1);
        end
      end
      GAP: begin
        if (cnt_r == CW'(GAP_CYC - 1)) begin
          if (|(bus.lock & bus.req & gnt_r)) begin
            grant_s = 1'b1;
          end else begin
            gnt_nxt   = 2'b00;
            last_nxt  = gnt_r[1];
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt_r + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // An invalid target is latched like any other but never selects or launches.
    if (grant_s) begin
      gnt_nxt   = gi_s ? 2'b10 : 2'b01;
      ok_nxt    = sel_valid(sel_s);
      ss_nxt    = ss_decode(sel_s);
      wrt_nxt   = sel_valid(sel_s);
      cmd_nxt   = cmd_s;
      state_nxt = SETUP;
    end else begin
      ok_nxt = ok_nxt;
    end
  end

  // State and registered outputs; reset favours requester 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      gnt_r     <= 2'b00;
      done_r    <= 2'b00;
      err_r     <= 1'b0;
      rd_data_r <= 16'h0000;
      spi_wrt_r <= 1'b0;
      spi_cmd_r <= 16'h0000;
      ss_n_r    <= 5'b11111;
      sel_ok_r  <= 1'b0;
      cnt_r     <= '0;
      last_r    <= 1'b1;
    end else begin
      state_r   <= state_nxt;
      gnt_r     <= gnt_nxt;
      done_r    <= done_nxt;
      err_r     <= err_nxt;
      rd_data_r <= rd_nxt;
      spi_wrt_r <= wrt_nxt;
      spi_cmd_r <= cmd_nxt;
      ss_n_r    <= ss_nxt;
      sel_ok_r  <= ok_nxt;
      cnt_r     <= cnt_nxt;
      last_r    <= last_nxt;
    end
  end

  assign bus.gnt     = gnt_r;
  assign bus.done    = done_r;
  assign bus.err     = err_r;
  assign bus.rd_data = rd_data_r;
  assign spi_wrt     = spi_wrt_r;
  assign spi_cmd     = spi_cmd_r;
  assign {EEP_ss_n, ch3_ss_n, ch2_ss_n, ch1_ss_n, trig_ss_n} = ss_n_r;

endmodule

// File: tb/tb_spi_bus_arb.sv
// Directed self-checking bench for spi_bus_arb with a small SPI master model
// and a slave-select monitor.
module tb_spi_bus_arb;
  localparam int GAP = 4;
  localparam int TMO = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        spi_wrt;
  logic [15:0] spi_cmd;
  logic        spi_done;
  logic [15:0] spi_rd_data;
  logic        trig_ss_n, ch1_ss_n, ch2_ss_n, ch3_ss_n, EEP_ss_n;

  spi_bus_arb_if bus ();

  spi_bus_arb #(.GAP_CYC(GAP), .TMO_CYC(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .spi_wrt    (spi_wrt),
    .spi_cmd    (spi_cmd),
    .spi_done   (spi_done),
    .spi_rd_data(spi_rd_data),
    .trig_ss_n  (trig_ss_n),
    .ch1_ss_n   (ch1_ss_n),
    .ch2_ss_n   (ch2_ss_n),
    .ch3_ss_n   (ch3_ss_n),
    .EEP_ss_n   (EEP_ss_n)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // SPI master model: answers spi_wrt with spi_done model_dly cycles later.
  logic        model_en   = 1'b0;
  int          model_dly  = 1;
  logic [15:0] model_data = 16'h0000;
  logic        model_done = 1'b0;
  logic        spur_done  = 1'b0;
  int          pend       = 0;

  assign spi_done    = model_done | spur_done;
  assign spi_rd_data = spur_done ? 16'hDEAD : model_data;

  always @(negedge clk) begin
    if (model_done) model_done = 1'b0;
    if (pend > 0) begin
      pend = pend - 1;
      if (pend == 0) model_done = 1'b1;
    end else if (spi_wrt && model_en) begin
      pend = model_dly;
    end
  end

  // Slave-select monitor: low/high run lengths, one-hot violations, launches.
  logic [4:0]  low_s;
  assign low_s = ~{EEP_ss_n, ch3_ss_n, ch2_ss_n, ch1_ss_n, trig_ss_n};
  int          low_run = 0, high_run = 0, last_low_len = 0, gap_len = 0;
  int          low_total = 0, wrt_cnt = 0, viol = 0;
  logic [4:0]  low_which = 5'd0;
  logic [15:0] wrt_cmd = 16'h0000;

  always @(negedge clk) begin
    if ($countones(low_s) > 1) viol++;
    if (low_s != 5'd0) begin
      if (low_run == 0) gap_len = high_run;
      low_run++;
      high_run = 0;
      low_which = low_s;
      low_total++;
    end else begin
      if (low_run != 0) last_low_len = low_run;
      low_run = 0;
      high_run++;
    end
    if (spi_wrt) begin
      wrt_cnt++;
      wrt_cmd = spi_cmd;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [1:0]  got_done;
  logic        got_err;
  logic [15:0] got_rd;
  int          lat;

  task automatic wait_done(input string tag, input int budget);
    got_done = 2'b00;
    got_err  = 1'b0;
    got_rd   = 16'h0000;
    lat      = 0;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk);
      #1;
      if (bus.done != 2'b00) begin
        got_done = bus.done;
        got_err  = bus.err;
        got_rd   = bus.rd_data;
        lat      = i;
        break;
      end
    end
    if (got_done == 2'b00) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s_wait: observed no done in %0d cycles, expected a done pulse", tag, budget);
    end
  endtask

  int   w0, l0;
  logic seen;

  initial begin
    rst_n    = 1'b0;
    bus.req  = 2'b00;
    bus.lock = 2'b00;
    bus.sel0 = 3'd0;
    bus.sel1 = 3'd0;
    bus.cmd0 = 16'h0000;
    bus.cmd1 = 16'h0000;
    cyc(2);
    chk("rst_gnt",  32'(bus.gnt), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_err",  32'(bus.err), 32'h0);
    chk("rst_rd",   32'(bus.rd_data), 32'h0);
    chk("rst_wrt",  32'(spi_wrt), 32'h0);
    chk("rst_cmd",  32'(spi_cmd), 32'h0);
    chk("rst_ss",   32'(low_s), 32'h0);
    rst_n = 1'b1;
    cyc(1);

    // Round-robin: both requesting, each re-requests right after its done.
    model_en = 1'b1; model_dly = 5; model_data = 16'h5A5A;
    bus.sel0 = 3'd2; bus.cmd0 = 16'h0A0A;
    bus.sel1 = 3'd3; bus.cmd1 = 16'h0B0B;
    bus.req  = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_done("alt", 200);
      chk("alt_gnt", 32'(got_done), 32'((i % 2 == 0) ? 2'b01 : 2'b10));
      chk("alt_err", 32'(got_err), 32'h0);
      chk("alt_rd",  32'(got_rd), 32'h5A5A);
      if (i == 3) bus.req = 2'b00;
      else        bus.req = bus.req & ~got_done;
      @(negedge clk); #1;
      chk("alt_ss", 32'(low_which), 32'((i % 2 == 0) ? 5'b00100 : 5'b01000));
      if (i > 0) chk("alt_gap", gap_len, GAP + 1);
      if (i < 3) bus.req = 2'b11;
    end
    cyc(GAP + 2);

    // Single ch1 transaction, 20-cycle SPI latency.
    w0 = wrt_cnt;
    bus.sel0 = 3'd1; bus.cmd0 = 16'h1234;
    model_dly = 20; model_data = 16'hBEEF;
    bus.req = 2'b01;
    wait_done("single", 100);
    bus.req = 2'b00;
    chk("single_done", 32'(got_done), 32'h1);
    chk("single_err",  32'(got_err), 32'h0);
    chk("single_rd",   32'(got_rd), 32'hBEEF);
    chk("single_lat",  lat, 22);
    @(negedge clk); #1;
    chk("single_lowlen", last_low_len, 21);
    chk("single_which",  32'(low_which), 32'h02);
    chk("single_wrts",   wrt_cnt - w0, 1);
    chk("single_cmd",    32'(wrt_cmd), 32'h1234);
    cyc(GAP + 2);

    // spi_done while idle must be ignored.
    spur_done = 1'b1;
    cyc(1);
    spur_done = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      cyc(1);
      if (bus.done != 2'b00) seen = 1'b1;
    end
    chk("spur_done", 32'(seen), 32'h0);
    chk("spur_rd",   32'(bus.rd_data), 32'hBEEF);

    // Locked EEP chain of three while requester 1 waits.
    bus.sel0 = 3'd4; bus.cmd0 = 16'hC0DE;
    bus.sel1 = 3'd0; bus.cmd1 = 16'h7777;
    model_dly = 3; model_data = 16'h1357;
    bus.lock = 2'b01;
    bus.req  = 2'b01;
    cyc(1);
    chk("lock_gnt0", 32'(bus.gnt), 32'h1);
    chk("lock_wrt0", 32'(spi_wrt), 32'h1);
    bus.req = 2'b11;
    for (int i = 0; i < 3; i++) begin
      wait_done("lock", 100);
      chk("lock_done", 32'(got_done), 32'h1);
      chk("lock_rd",   32'(got_rd), 32'h1357);
      if (i == 2) begin
        bus.req  = 2'b10;
        bus.lock = 2'b00;
        model_data = 16'h2468;
      end
      @(negedge clk); #1;
      chk("lock_which", 32'(low_which), 32'h10);
      if (i > 0) chk("lock_gap", gap_len, GAP);
    end
    wait_done("lock_next", 100);
    bus.req = 2'b00;
    chk("lock_next_done", 32'(got_done), 32'h2);
    chk("lock_next_rd",   32'(got_rd), 32'h2468);
    @(negedge clk); #1;
    chk("lock_next_gap",   gap_len, GAP + 1);
    chk("lock_next_which", 32'(low_which), 32'h01);
    cyc(GAP + 2);

    // Invalid target: no select, no launch, done+err one cycle after grant.
    w0 = wrt_cnt;
    l0 = low_total;
    bus.sel1 = 3'd6;
    bus.req  = 2'b10;
    wait_done("inv", 20);
    bus.req = 2'b00;
    chk("inv_done", 32'(got_done), 32'h2);
    chk("inv_err",  32'(got_err), 32'h1);
    chk("inv_rd",   32'(got_rd), 32'h2468);
    chk("inv_lat",  lat, 2);
    @(negedge clk); #1;
    chk("inv_wrts", wrt_cnt - w0, 0);
    chk("inv_low",  low_total - l0, 0);
    cyc(GAP + 2);

    // Timeout: the SPI master never answers.
    model_en = 1'b0;
    bus.sel0 = 3'd3; bus.cmd0 = 16'h0F0F;
    bus.req  = 2'b01;
    wait_done("tmo", TMO + 100);
    bus.req = 2'b00;
    chk("tmo_done", 32'(got_done), 32'h1);
    chk("tmo_err",  32'(got_err), 32'h1);
    chk("tmo_rd",   32'(got_rd), 32'h2468);
    chk("tmo_lat",  lat, TMO + 2);
    @(negedge clk); #1;
    chk("tmo_lowlen", last_low_len, TMO + 1);
    chk("tmo_ss",     32'(low_s), 32'h0);
    cyc(GAP + 2);
    model_en = 1'b1; model_dly = 2; model_data = 16'h2222;
    bus.sel1 = 3'd0; bus.cmd1 = 16'h1111;
    bus.req  = 2'b10;
    wait_done("post_tmo", 50);
    bus.req = 2'b00;
    chk("post_tmo_done", 32'(got_done), 32'h2);
    chk("post_tmo_err",  32'(got_err), 32'h0);
    chk("post_tmo_rd",   32'(got_rd), 32'h2222);
    chk("post_tmo_lat",  lat, 4);
    cyc(GAP + 2);

    // Asynchronous reset in the middle of a transfer.
    model_en = 1'b0;
    bus.sel0 = 3'd2;
    bus.req  = 2'b01;
    cyc(6);
    chk("mid_ss_low", 32'(low_s), 32'h04);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ss",  32'(low_s), 32'h0);
    chk("mid_rst_gnt", 32'(bus.gnt), 32'h0);
    chk("mid_rst_wrt", 32'(spi_wrt), 32'h0);
    bus.req = 2'b00;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    chk("mid_rst_rd", 32'(bus.rd_data), 32'h0);
    model_en = 1'b1; model_dly = 4; model_data = 16'h3C3C;
    bus.sel0 = 3'd1; bus.cmd0 = 16'h4242;
    bus.req  = 2'b01;
    wait_done("post_rst", 50);
    bus.req = 2'b00;
    chk("post_rst_done", 32'(got_done), 32'h1);
    chk("post_rst_err",  32'(got_err), 32'h0);
    chk("post_rst_rd",   32'(got_rd), 32'h3C3C);
    chk("post_rst_lat",  lat, 6);
    @(negedge clk); #1;
    chk("post_rst_cmd",    32'(wrt_cmd), 32'h4242);
    chk("post_rst_lowlen", last_low_len, 5);

    chk("ss_onehot", viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
